peripheral_adc_scan: RTL and testbench

PERIPHERAL_ADC_SCAN -- requirements
Module: peripheral_adc_scan

---
 rtl/peripheral_adc_scan.sv | 212 +++++++++++++++++++++
 tb/tb_peripheral_adc_scan.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_adc_scan.sv
// Multi-channel ADC scan controller with a CPU register interface.
// Each masked channel gets SETUP/LATCH/START/EOC-wait/READ; results are kept per channel.
module peripheral_adc_scan #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 8,
  parameter int START_W = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       d_in,
  input  logic              cs,
  input  logic [3:0]        addr,
  input  logic              rd,
  input  logic              wr,
  output logic [15:0]       d_out,
  input  logic              eoc,
  input  logic [DATA_W-1:0] datain,
  output logic [2:0]        add,
  output logic              ale,
  output logic              start,
  output logic              oe
);

  typedef enum logic [2:0] {
    IDLE, SETUP, LATCH, STRT, WLOW, WHIGH, READ, NEXT
  } state_t;

  localparam logic [7:0] CH_MASK = 8'((9'd1 << NUM_CH) - 9'd1);
  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam int SCW = $clog2(START_W + 1);

  state_t            state;
  logic [7:0]        mask;
  logic              cont;
  logic [2:0]        rsel;
  logic [2:0]        ch;
  logic              busy, done, tout, ovr;
  logic [7:0]        new_flg;
  logic [DATA_W-1:0] result [8];
  logic [WCW-1:0]    wcnt;
  logic [SCW-1:0]    scnt;
  logic              ocnt;

  logic        wr_ctrl, wr_rsel, rd_stat, rd_res, rd_en;
  logic [7:0]  wmask;
  logic [2:0]  go_ch, low_ch, nxt_ch;
  logic        nxt_ok, wait_exp;
  logic [15:0] rdata, res_word;
  logic        unused_d_in;

  assign unused_d_in = ^d_in[7:2];

  assign rd_en    = cs && rd;
  assign wr_ctrl  = cs && wr && (addr == 4'h0);
  assign wr_rsel  = cs && wr && (addr == 4'h4);
  assign rd_stat  = rd_en && (addr == 4'h2);
  assign rd_res   = rd_en && (addr == 4'h6);
  assign wmask    = d_in[15:8] & CH_MASK;
  assign wait_exp = (wcnt == WCW'(TIMEOUT - 1));

  // descending loops so the lowest qualifying bit wins
  always_comb begin
    go_ch  = '0;
    low_ch = '0;
    nxt_ch = '0;
    nxt_ok = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (wmask[i]) go_ch = 3'(i);
      if (mask[i]) low_ch = 3'(i);
      if (mask[i] && (3'(i) > ch)) begin
        nxt_ch = 3'(i);
        nxt_ok = 1'b1;
      end
    end
  end

  always_comb begin
    res_word = '0;
    res_word[DATA_W-1:0] = result[rsel];
    res_word[15] = new_flg[rsel];
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      addr == 4'h0: rdata = {mask, 6'b0, cont, 1'b0};
      addr == 4'h2: rdata = {9'b0, ch, ovr, tout, done, busy};
      addr == 4'h4: rdata = {13'b0, rsel};
      addr == 4'h6: rdata = res_word;
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      d_out   <= '0;
      add     <= '0;
      ale     <= 1'b0;
      start   <= 1'b0;
      oe      <= 1'b0;
      mask    <= '0;
      cont    <= 1'b0;
      rsel    <= '0;
      ch      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      tout    <= 1'b0;
      ovr     <= 1'b0;
      new_flg <= '0;
      wcnt    <= '0;
      scnt    <= '0;
      ocnt    <= 1'b0;
      for (int i = 0; i < 8; i++) result[i] <= '0;
    end else begin
      d_out <= rd_en ? rdata : '0;
      if (wr_ctrl) begin
        cont <= d_in[1];
        mask <= wmask;
      end
      if (wr_rsel) rsel <= d_in[2:0];
      // read-clears first so same-cycle sets below take priority
      if (rd_stat) begin
        done <= 1'b0;
        tout <= 1'b0;
        ovr  <= 1'b0;
      end
      if (rd_res) new_flg[rsel] <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wr_ctrl && d_in[0] && (wmask != '0)) begin
            ch    <= go_ch;
            add   <= go_ch;
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          ale   <= 1'b1;
          state <= LATCH;
        end
        LATCH: begin
          ale   <= 1'b0;
          start <= 1'b1;
          scnt  <= '0;
          state <= STRT;
        end
        STRT: begin
          if (scnt == SCW'(START_W - 1)) begin
            start <= 1'b0;
            wcnt  <= '0;
            state <= WLOW;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        WLOW: begin
          wcnt <= wcnt + 1'b1;
          if (!eoc) begin
            state <= WHIGH;
          end else if (wait_exp) begin
            tout  <= 1'b1;
            state <= NEXT;
          end
        end
        WHIGH: begin
          wcnt <= wcnt + 1'b1;
          if (eoc) begin
            oe    <= 1'b1;
            ocnt  <= 1'b0;
            state <= READ;
          end else if (wait_exp) begin
            tout  <= 1'b1;
            state <= NEXT;
          end
        end
        READ: begin
          if (!ocnt) begin
            ocnt <= 1'b1;
          end else begin
            oe          <= 1'b0;
            result[ch]  <= datain;
            new_flg[ch] <= 1'b1;
            if (new_flg[ch]) ovr <= 1'b1;
            state <= NEXT;
          end
        end
        NEXT: begin
          wcnt <= '0;
          if (nxt_ok) begin
            ch    <= nxt_ch;
            add   <= nxt_ch;
            state <= SETUP;
          end else begin
            done <= 1'b1;
            if (cont && (mask != '0)) begin
              ch    <= low_ch;
              add   <= low_ch;
              state <= SETUP;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_adc_scan.sv
// Directed bench for peripheral_adc_scan with a simple ADC eoc/data model.
// Expected register values are hand-derived from the register map.
module tb_peripheral_adc_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] d_in = '0;
  logic        cs = 1'b0;
  logic [3:0]  addr = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] d_out;
  logic        eoc = 1'b1;
  logic [7:0]  datain;
  logic [2:0]  add;
  logic        ale, start, oe;

  int checks = 0;
  int errors = 0;

  logic [7:0] data_tab [8];
  logic       stuck = 1'b0;
  int         lcnt = 0;

  int         ale_cnt = 0;
  int         start_cyc = 0;
  int         overlap = 0;
  logic [2:0] add_log [256];

  always #5 clk = ~clk;

  peripheral_adc_scan #(
    .NUM_CH(4), .DATA_W(8), .START_W(2), .TIMEOUT(20)
  ) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .cs(cs), .addr(addr),
    .rd(rd), .wr(wr), .d_out(d_out), .eoc(eoc), .datain(datain),
    .add(add), .ale(ale), .start(start), .oe(oe)
  );

  assign datain = data_tab[add];

  // ADC: eoc drops while start is seen, rises 3 cycles after start ends
  always @(posedge clk) begin
    if (stuck) begin
      eoc  <= 1'b1;
      lcnt <= 0;
    end else if (start) begin
      eoc  <= 1'b0;
      lcnt <= 3;
    end else if (lcnt > 0) begin
      lcnt <= lcnt - 1;
      if (lcnt == 1) eoc <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (ale) begin
      add_log[ale_cnt[7:0]] = add;
      ale_cnt++;
    end
    if (start) start_cyc++;
    if ((32'(ale) + 32'(start) + 32'(oe)) > 1) overlap++;
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; d_in = '0;
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [15:0] v);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    v = d_out;
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [15:0] v;
    int a0, s0, done_seen, busy_seen;
    bit found;
    for (int i = 0; i < 8; i++) data_tab[i] = '0;

    // reset state
    idle(3);
    chk("rst_dout", d_out, 16'h0000);
    chk("rst_pins", {12'b0, add, ale, start, oe}, 16'h0000);
    rst = 1'b1;
    idle(2);
    rd_reg(4'h2, v); chk("rst_status", v, 16'h0000);

    // two-channel sweep, mask 0x05
    data_tab[0] = 8'hA5; data_tab[2] = 8'h3C;
    a0 = ale_cnt; s0 = start_cyc;
    wr_reg(4'h0, 16'h0501);
    idle(60);
    chk("sw_ale_cnt", 16'(ale_cnt - a0), 16'd2);
    chk("sw_add0", {13'b0, add_log[a0[7:0]]}, 16'd0);
    chk("sw_add1", {13'b0, add_log[8'(a0 + 1)]}, 16'd2);
    chk("sw_start", 16'(start_cyc - s0), 16'd4);
    rd_reg(4'h2, v); chk("sw_status", v, 16'h0022);
    rd_reg(4'h2, v); chk("sw_status2", v, 16'h0020);
    wr_reg(4'h4, 16'h0002);
    rd_reg(4'h6, v); chk("sw_res2", v, 16'h803C);
    rd_reg(4'h6, v); chk("sw_res2_rr", v, 16'h003C);
    wr_reg(4'h4, 16'h0000);
    rd_reg(4'h6, v); chk("sw_res0", v, 16'h80A5);

    // GO with empty mask, unmapped address
    a0 = ale_cnt;
    wr_reg(4'h0, 16'h0001);
    idle(10);
    chk("m0_ale", 16'(ale_cnt - a0), 16'd0);
    rd_reg(4'h2, v); chk("m0_status", v, 16'h0020);
    rd_reg(4'hA, v); chk("m0_addrA", v, 16'h0000);
    rd_reg(4'h0, v); chk("m0_ctrl", v, 16'h0000);
    chk("m0_dout_idle", d_out, 16'h0000);

    // timeout with eoc stuck high
    rst = 1'b0; idle(2); rst = 1'b1; idle(1);
    stuck = 1'b1;
    wr_reg(4'h0, 16'h0101);
    idle(40);
    rd_reg(4'h6, v); chk("to_res0", v, 16'h0000);
    rd_reg(4'h2, v); chk("to_status", v, 16'h0006);
    rd_reg(4'h2, v); chk("to_status2", v, 16'h0000);
    stuck = 1'b0;
    idle(2);

    // STATUS held in read every cycle: DONE must still be observed once
    data_tab[1] = 8'h5A;
    wr_reg(4'h0, 16'h0201);
    cs = 1'b1; rd = 1'b1; addr = 4'h2;
    done_seen = 0; busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (d_out[1]) done_seen++;
      if (d_out[0]) busy_seen++;
    end
    cs = 1'b0; rd = 1'b0;
    chk("rr_done_seen", 16'(done_seen), 16'd1);
    chk("rr_busy_seen", {15'b0, busy_seen != 0}, 16'd1);
    rd_reg(4'h2, v); chk("rr_status", v, 16'h0010);

    // continuous scan, overrun, then stop after sweep
    data_tab[0] = 8'h11; data_tab[1] = 8'h22;
    wr_reg(4'h0, 16'h0303);
    idle(60);
    data_tab[0] = 8'h33; data_tab[1] = 8'h44;
    idle(60);
    rd_reg(4'h2, v); chk("ct_status", v & 16'h000F, 16'h000B);
    wr_reg(4'h0, 16'h0300);
    idle(60);
    rd_reg(4'h2, v); chk("ct_status_end", v, 16'h001A);
    wr_reg(4'h4, 16'h0000);
    rd_reg(4'h6, v); chk("ct_res0", v, 16'h8033);
    wr_reg(4'h4, 16'h0001);
    rd_reg(4'h6, v); chk("ct_res1", v, 16'h8044);

    // reset during start pulse
    wr_reg(4'h4, 16'h0003);
    wr_reg(4'h0, 16'h0401);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (start) found = 1'b1;
    end
    chk("rs_start_seen", {15'b0, found}, 16'd1);
    chk("rs_add_pre", {13'b0, add}, 16'd2);
    #2 rst = 1'b0;
    #1 chk("rs_pins", {12'b0, add, ale, start, oe}, 16'h0000);
    chk("rs_dout", d_out, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    a0 = ale_cnt;
    idle(20);
    chk("rs_no_act", 16'(ale_cnt - a0), 16'd0);
    rd_reg(4'h0, v); chk("rs_ctrl", v, 16'h0000);
    rd_reg(4'h2, v); chk("rs_status", v, 16'h0000);
    rd_reg(4'h4, v); chk("rs_rsel", v, 16'h0000);
    rd_reg(4'h6, v); chk("rs_result", v, 16'h0000);
    chk("overlap", 16'(overlap), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
